// File: rtl/ctrl_pkg.sv
// Shared configuration types and helpers for the TDM/I2S transmit framer.
package ctrl_pkg;

  typedef enum logic [1:0] {STD_I2S, STD_MSB, STD_LSB} standard_t;
  typedef enum logic [1:0] {WS_16, WS_24, WS_32} word_size_t;
  typedef enum logic {FS_16, FS_32} frame_size_t;
  typedef enum logic [1:0] {TX_IDLE, TX_RUN, TX_DRAIN} tx_state_t;

  localparam int SLOT16 = 16;
  localparam int SLOT32 = 32;

  function automatic int word_bits(word_size_t wsz);
    case (wsz)
      WS_16:   return 16;
      WS_24:   return 24;
      default: return 32;
    endcase
  endfunction

  function automatic int slot_bits(frame_size_t fsz);
    return (fsz == FS_32) ? SLOT32 : SLOT16;
  endfunction

  // Slot image left-aligned in 32 bits: bit 31 is the first bit on the wire.
  function automatic logic [31:0] slot_pattern(logic [31:0] w, standard_t std,
                                               word_size_t wsz, frame_size_t fsz);
    int          fb;
    int          n;
    logic [31:0] v;
    fb = slot_bits(fsz);
    n  = (word_bits(wsz) < fb) ? word_bits(wsz) : fb;
    v  = (n == 32) ? w : (w & ((32'd1 << n) - 32'd1));
    if (std == STD_LSB) return v << (32 - fb);
    return v << (32 - n);
  endfunction

endpackage

// File: rtl/tdm_tx_framer_sck_div.sv
// Bit-clock divider: toggles sck every CLK_DIV clk cycles, flags the edge about to happen.
module sck_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic sck,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(CLK_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise_tick = en && wrap && !sck;
  assign fall_tick = en && wrap && sck;

endmodule

// File: rtl/tdm_tx_framer.sv
// Master TDM/I2S transmit framer: NUM_CH slots per frame, valid/ready sample input.
// Optional build macro TDM_TX_MONO_EN adds a mono input (one sample replicated to all slots).
module tdm_tx_framer
  import ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int MAX_WORD = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tran_en,
  input  logic                      stop,
  input  logic                      mute,
`ifdef TDM_TX_MONO_EN
  input  logic                      mono,
`endif
  input  standard_t                 standard,
  input  word_size_t                word_size,
  input  frame_size_t               frame_size,
  input  logic [MAX_WORD-1:0]       s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [$clog2(NUM_CH)-1:0] s_ch,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);

  tx_state_t     state_q, state_d;
  standard_t     std_q, std_e;
  word_size_t    wsz_q, wsz_e;
  frame_size_t   fsz_q, fsz_e;
  logic [CH_W-1:0] slot_q, slot_d, s_ch_q;
  logic [4:0]    bit_q, bit_d, last_bit;
  logic [31:0]   sh_q, sh_d, pat, pat_sel, mono_pat_q;
  logic          prev_q, prev_d, sd_q, sd_d, ws_q, ws_d, raw;
  logic [MAX_WORD-1:0] hold_q;
  logic          hold_full, underrun_q;
  logic          start_run, active, bit_start, slot_end, frame_end;
  logic          load, take, accept, mono_e;
  logic          fall_tick, rise_tick, div_clr;

  sck_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != TX_IDLE),
    .clr       (div_clr),
    .sck       (sck),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

`ifdef TDM_TX_MONO_EN
  logic mono_q;
  assign mono_e = (state_q == TX_IDLE) ? mono : mono_q;
`else
  assign mono_e     = 1'b0;
  assign mono_pat_q = '0;
`endif

  // Config is taken straight from the inputs on the entry cycle, from the latches afterwards.
  assign start_run = (state_q == TX_IDLE) && tran_en && !stop;
  assign active    = (state_q != TX_IDLE) && tran_en;
  assign std_e     = start_run ? standard   : std_q;
  assign wsz_e     = start_run ? word_size  : wsz_q;
  assign fsz_e     = start_run ? frame_size : fsz_q;
  assign last_bit  = 5'(slot_bits(fsz_e) - 1);
  assign bit_start = start_run || (active && fall_tick);
  assign slot_end  = (bit_q == last_bit);
  assign frame_end = active && fall_tick && slot_end && (slot_q == CH_W'(NUM_CH - 1));
  assign accept    = s_valid && !hold_full;
  assign div_clr   = (state_q != TX_IDLE) && (state_d == TX_IDLE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (start_run) state_d = TX_RUN;
      TX_RUN:   if (!tran_en) state_d = TX_IDLE; else if (stop) state_d = TX_DRAIN;
      TX_DRAIN: if (!tran_en || frame_end) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    slot_d = slot_q;
    bit_d  = bit_q;
    if (start_run) begin
      slot_d = '0;
      bit_d  = '0;
    end else if (bit_start) begin
      if (slot_end) begin
        bit_d  = '0;
        slot_d = (slot_q == CH_W'(NUM_CH - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
    if (state_d == TX_IDLE) begin
      slot_d = '0;
      bit_d  = '0;
    end
  end

  // A new word arriving in the load cycle bypasses the empty holding register.
  assign load = bit_start && (state_d != TX_IDLE) && (start_run || slot_end);
  assign take = load && !(mono_e && (slot_d != '0));
  assign pat  = slot_pattern(32'(hold_full ? hold_q : s_data), std_e, wsz_e, fsz_e);

  always_comb begin
    pat_sel = mono_pat_q;
    if (take) pat_sel = (hold_full || accept) ? pat : '0;
  end

  always_comb begin
    raw    = 1'b0;
    sh_d   = sh_q;
    prev_d = prev_q;
    sd_d   = sd_q;
    ws_d   = ws_q;
    if (load) begin
      raw  = pat_sel[31];
      sh_d = {pat_sel[30:0], 1'b0};
    end else if (bit_start) begin
      raw  = sh_q[31];
      sh_d = {sh_q[30:0], 1'b0};
    end
    if (bit_start && (state_d != TX_IDLE)) begin
      if (std_e == STD_I2S) begin
        sd_d   = (start_run ? 1'b0 : prev_q) & ~mute;
        prev_d = raw;
      end else begin
        sd_d = raw & ~mute;
      end
      ws_d = (NUM_CH == 2) ? (slot_d == CH_W'(1)) : ((slot_d == '0) && (bit_d == '0));
    end
    if (state_d == TX_IDLE) begin
      sd_d = 1'b0;
      ws_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      std_q      <= STD_I2S;
      wsz_q      <= WS_16;
      fsz_q      <= FS_16;
      slot_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      prev_q     <= 1'b0;
      sd_q       <= 1'b0;
      ws_q       <= 1'b0;
      hold_full  <= 1'b0;
      underrun_q <= 1'b0;
      s_ch_q     <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      prev_q  <= prev_d;
      sd_q    <= sd_d;
      ws_q    <= ws_d;
      if (start_run) begin
        std_q      <= standard;
        wsz_q      <= word_size;
        fsz_q      <= frame_size;
        underrun_q <= 1'b0;
      end
      if (take) begin
        if (hold_full)    hold_full  <= 1'b0;
        else if (!accept) underrun_q <= 1'b1;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
      if ((state_q != TX_IDLE) && !tran_en)
        s_ch_q <= '0;
      else if (accept && !mono_e)
        s_ch_q <= (s_ch_q == CH_W'(NUM_CH - 1)) ? '0 : s_ch_q + 1'b1;
    end
  end

  // NOTE: the holding data needs no reset; hold_full alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept && !take) hold_q <= s_data;
  end

`ifdef TDM_TX_MONO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mono_q     <= 1'b0;
      mono_pat_q <= '0;
    end else begin
      if (start_run) mono_q <= mono;
      if (load && (slot_d == '0)) mono_pat_q <= pat_sel;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) assert (!(rise_tick && fall_tick));
  end

  assign s_ready  = !hold_full;
  assign s_ch     = s_ch_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = underrun_q;
  assign busy     = (state_q != TX_IDLE);

endmodule
